// File: rtl/prbs_pkg.sv
// PRBS-8 definitions shared by the pattern generator and the checker.
// Polynomial x^8+x^6+x^5+x^4+1 in Fibonacci form, period 255.
package prbs_pkg;

    localparam int unsigned PRBS8_W    = 8;
    localparam logic [7:0]  PRBS8_TAPS = 8'hB8;

    typedef enum logic [1:0] {
        SEED,
        VERIFY,
        LOCKED
    } state_e;

    // Feedback bit: XOR of register bits 7, 5, 4 and 3.
    function automatic logic prbs8_next(input logic [PRBS8_W-1:0] s);
        return ^(s & PRBS8_TAPS);
    endfunction

endpackage

// File: rtl/prbs_checker.sv
// Serial PRBS-8 checker: seeds from the received stream, verifies, locks,
// then flywheels on its own prediction and counts windowed bit errors.
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int unsigned SYNC_GOOD = 16,
    parameter int unsigned LOSS_ERRS = 4,
    parameter int unsigned WINDOW    = 64,
    parameter int unsigned ERR_CNT_W = 16,
    parameter int unsigned BIT_CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic                 in_bit,
    input  logic                 err_clear,
    output logic                 locked,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [BIT_CNT_W-1:0] bit_count
);

    localparam int unsigned GOOD_W = $clog2(SYNC_GOOD + 1);
    localparam int unsigned CNT_W  = (GOOD_W > 3) ? GOOD_W : 3;
    localparam int unsigned WIN_W  = $clog2(WINDOW);
    localparam int unsigned WERR_W = $clog2(LOSS_ERRS + 1);

    state_e               state_q,     state_d;
    logic [PRBS8_W-1:0]   s_q,         s_d;
    logic [CNT_W-1:0]     cnt_q,       cnt_d;
    logic [WIN_W-1:0]     win_bit_q,   win_bit_d;
    logic [WERR_W-1:0]    win_err_q,   win_err_d;
    logic                 locked_q,    locked_d;
    logic                 err_pulse_q, err_pulse_d;
    logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
    logic [BIT_CNT_W-1:0] bit_count_q, bit_count_d;

    logic                 pred;
    logic [WERR_W-1:0]    win_err_inc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= SEED;
            s_q         <= '0;
            cnt_q       <= '0;
            win_bit_q   <= '0;
            win_err_q   <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
            bit_count_q <= '0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            cnt_q       <= cnt_d;
            win_bit_q   <= win_bit_d;
            win_err_q   <= win_err_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
            bit_count_q <= bit_count_d;
        end
    end

    // cnt_q counts seed bits in SEED and good predictions in VERIFY.
    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        cnt_d       = cnt_q;
        win_bit_d   = win_bit_q;
        win_err_d   = win_err_q;
        err_pulse_d = 1'b0;
        err_count_d = err_count_q;
        bit_count_d = bit_count_q;
        pred        = prbs8_next(s_q);
        win_err_inc = win_err_q + WERR_W'(in_bit ^ pred);

        if (in_valid) begin
            case (state_q)
                SEED: begin
                    s_d   = {s_q[6:0], in_bit};
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(7)) begin
                        cnt_d = '0;
                        if ({s_q[6:0], in_bit} != 8'h00) begin
                            state_d = VERIFY;
                        end
                    end
                end
                VERIFY: begin
                    s_d = {s_q[6:0], in_bit};
                    if (in_bit == pred) begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(SYNC_GOOD - 1)) begin
                            state_d   = LOCKED;
                            win_bit_d = '0;
                            win_err_d = '0;
                        end
                    end else begin
                        state_d = SEED;
                        cnt_d   = '0;
                    end
                end
                LOCKED: begin
                    // Flywheel on the prediction so line errors never reach s.
                    s_d = {s_q[6:0], pred};
                    if (bit_count_q != '1) begin
                        bit_count_d = bit_count_q + BIT_CNT_W'(1);
                    end
                    win_bit_d = (win_bit_q == WIN_W'(WINDOW - 1)) ? '0 : win_bit_q + WIN_W'(1);
                    if (in_bit != pred) begin
                        err_pulse_d = 1'b1;
                        if (err_count_q != '1) begin
                            err_count_d = err_count_q + ERR_CNT_W'(1);
                        end
                    end
                    // The wrapping bit's error still belongs to the ending window.
                    if (win_err_inc == WERR_W'(LOSS_ERRS)) begin
                        state_d = SEED;
                        cnt_d   = '0;
                    end else if (win_bit_q == WIN_W'(WINDOW - 1)) begin
                        win_err_d = '0;
                    end else begin
                        win_err_d = win_err_inc;
                    end
                end
                default: begin
                    state_d = SEED;
                    cnt_d   = '0;
                end
            endcase
        end

        if (err_clear) begin
            err_count_d = '0;
            bit_count_d = '0;
        end

        locked_d = (state_d == LOCKED);
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;
    assign bit_count = bit_count_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: a behavioural checker model fills a
// scoreboard each cycle, plus fixed-value checks at the key lock/loss points.
module tb_prbs_checker;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_bit;
    logic        err_clear;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;
    logic [31:0] bit_count;

    prbs_checker dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .err_clear (err_clear),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count),
        .bit_count (bit_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic        lk;
        logic        ep;
        logic [15:0] ec;
        logic [31:0] bc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Pattern source, same LFSR as the on-chip generator.
    logic [7:0] gen_r;

    // Reference checker state.
    int          m_st, m_cnt, m_wb, m_we;
    logic [7:0]  m_s;
    logic        m_ep;
    logic [15:0] m_ec;
    logic [31:0] m_bc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    task automatic next_gen(output logic b);
        b     = gen_r[7] ^ gen_r[5] ^ gen_r[4] ^ gen_r[3];
        gen_r = {gen_r[6:0], b};
    endtask

    // One clock: drive inputs, advance the model, then compare at edge+1.
    task automatic step(input logic v, input logic b, input logic clr, input logic rst);
        exp_t e;
        logic p;
        reset     = rst;
        in_valid  = v;
        in_bit    = b;
        err_clear = clr;
        if (rst) begin
            m_st = 0; m_s = 8'h00; m_cnt = 0; m_wb = 0; m_we = 0;
            m_ep = 1'b0; m_ec = 16'h0; m_bc = 32'h0;
        end else begin
            m_ep = 1'b0;
            p    = m_s[7] ^ m_s[5] ^ m_s[4] ^ m_s[3];
            if (v) begin
                if (m_st == 0) begin
                    m_s = {m_s[6:0], b};
                    m_cnt++;
                    if (m_cnt == 8) begin
                        m_cnt = 0;
                        if (m_s != 8'h00) m_st = 1;
                    end
                end else if (m_st == 1) begin
                    m_s = {m_s[6:0], b};
                    if (b == p) begin
                        m_cnt++;
                        if (m_cnt == 16) begin
                            m_st = 2; m_wb = 0; m_we = 0;
                        end
                    end else begin
                        m_st = 0; m_cnt = 0;
                    end
                end else begin
                    m_s = {m_s[6:0], p};
                    if (m_bc != 32'hFFFF_FFFF) m_bc++;
                    if (b != p) begin
                        m_ep = 1'b1;
                        if (m_ec != 16'hFFFF) m_ec++;
                        m_we++;
                    end
                    m_wb++;
                    if (m_we == 4) begin
                        m_st = 0; m_cnt = 0;
                    end else if (m_wb == 64) begin
                        m_wb = 0; m_we = 0;
                    end
                end
            end
            if (clr) begin
                m_ec = 16'h0;
                m_bc = 32'h0;
            end
        end
        e.lk = (m_st == 2);
        e.ep = m_ep;
        e.ec = m_ec;
        e.bc = m_bc;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("sb_locked",    32'(locked),    32'(e.lk));
        chk("sb_err_pulse", 32'(err_pulse), 32'(e.ep));
        chk("sb_err_count", 32'(err_count), 32'(e.ec));
        chk("sb_bit_count", bit_count,      e.bc);
    endtask

    task automatic clean(input int n);
        logic b;
        for (int i = 0; i < n; i++) begin
            next_gen(b);
            step(1'b1, b, 1'b0, 1'b0);
        end
    endtask

    task automatic flip();
        logic b;
        next_gen(b);
        step(1'b1, ~b, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        gen_r = 8'h01;
    endtask

    initial begin
        logic b;
        int   acc;
        reset = 1'b1; in_valid = 1'b0; in_bit = 1'b0; err_clear = 1'b0;
        gen_r = 8'h01;

        // Reset state
        do_reset();
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        chk("rst_bit_count", bit_count, 32'd0);

        // Clean stream: lock after the 24th bit, then bit_count runs
        clean(23);
        chk("lock_not_yet", 32'(locked), 32'd0);
        clean(1);
        chk("lock_at_24", 32'(locked), 32'd1);
        clean(6);
        chk("bits_after_lock", bit_count, 32'd6);
        chk("clean_err_count", 32'(err_count), 32'd0);

        // Single flipped bit while locked: one pulse, flywheel holds
        flip();
        chk("single_pulse", 32'(err_pulse), 32'd1);
        chk("single_count", 32'(err_count), 32'd1);
        chk("single_locked", 32'(locked), 32'd1);
        clean(10);
        chk("flywheel_no_pulse", 32'(err_pulse), 32'd0);
        chk("flywheel_count", 32'(err_count), 32'd1);

        // Three more errors in the same window: lock lost on the 4th
        for (int k = 0; k < 3; k++) begin
            clean(2);
            flip();
        end
        chk("loss_locked", 32'(locked), 32'd0);
        chk("loss_pulse", 32'(err_pulse), 32'd1);
        chk("loss_count", 32'(err_count), 32'd4);

        // Re-lock needs 24 further bits
        clean(23);
        chk("relock_not_yet", 32'(locked), 32'd0);
        clean(1);
        chk("relock", 32'(locked), 32'd1);

        // Clear, then 3 errors per window incl. straddling a window wrap
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("clear_count", 32'(err_count), 32'd0);
        for (int i = 0; i < 256; i++) begin
            if (i == 10 || i == 20 || i == 30 || (i >= 125 && i <= 130)) flip();
            else clean(1);
        end
        chk("window_locked", 32'(locked), 32'd1);
        chk("window_count", 32'(err_count), 32'd9);
        chk("window_bits", bit_count, 32'd256);

        // err_clear on the same cycle as an error bit
        next_gen(b);
        step(1'b1, ~b, 1'b1, 1'b0);
        chk("clr_err_count", 32'(err_count), 32'd0);
        chk("clr_err_pulse", 32'(err_pulse), 32'd1);
        chk("clr_bit_count", bit_count, 32'd0);
        chk("clr_locked", 32'(locked), 32'd1);

        // Reset while locked
        clean(5);
        next_gen(b);
        step(1'b1, b, 1'b0, 1'b1);
        chk("rstl_locked", 32'(locked), 32'd0);
        chk("rstl_bit_count", bit_count, 32'd0);
        chk("rstl_err_pulse", 32'(err_pulse), 32'd0);

        // Error during VERIFY: back to SEED, no count, 24 more to lock
        do_reset();
        clean(13);
        flip();
        chk("verify_err_locked", 32'(locked), 32'd0);
        chk("verify_err_count", 32'(err_count), 32'd0);
        chk("verify_err_pulse", 32'(err_pulse), 32'd0);
        clean(23);
        chk("verify_relock_not_yet", 32'(locked), 32'd0);
        clean(1);
        chk("verify_relock", 32'(locked), 32'd1);

        // Clean stream with random in_valid gaps: lock counted in accepted bits
        do_reset();
        acc = 0;
        while (acc < 30) begin
            for (int g = $urandom_range(0, 3); g > 0; g--) begin
                step(1'b0, 1'($urandom), 1'b0, 1'b0);
            end
            clean(1);
            acc++;
            if (acc == 23) chk("gap_not_yet", 32'(locked), 32'd0);
            if (acc == 24) chk("gap_lock", 32'(locked), 32'd1);
        end

        // All-zero stream never seeds
        do_reset();
        for (int i = 0; i < 100; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("zero_locked", 32'(locked), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prbs_checker.md
# prbs_checker

Serial PRBS-8 checker, the receive end of the on-chip 8-bit LFSR pattern source (polynomial x^8+x^6+x^5+x^4+1, Fibonacci form, period 255). Self-synchronises to an incoming bit stream, declares lock after a run of correct predictions, then counts bit errors and drops lock when errors exceed a windowed threshold. Used in the NPC self-test path to validate links and buffers driven by the LFSR generator.

## Interface
- SYNC_GOOD, 16: consecutive correct predictions required to declare lock.
- LOSS_ERRS, 4: errors within one window that force loss of lock.
- WINDOW, 64: window length in accepted bits while locked.
- ERR_CNT_W, 16: width of err_count.
- BIT_CNT_W, 32: width of bit_count.
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  in_bit is accepted this cycle.
- in_bit  in  1  received stream bit, equal to the generator's newest bit (its register bit 0 after each shift).
- err_clear  in  1  clears err_count and bit_count.
- locked  out  1  checker is synchronised.
- err_pulse  out  1  one-cycle pulse per errored bit while locked.
- err_count  out  ERR_CNT_W  saturating count of errors while locked.
- bit_count  out  BIT_CNT_W  saturating count of bits checked while locked.

## Operation
- Internal 8-bit shift register s; predicted bit p = s[7]^s[5]^s[4]^s[3]; every accepted bit shifts s <= {s[6:0], x}.
- Nothing changes on cycles with in_valid=0 except err_clear handling and err_pulse returning to 0.
- States:
  - SEED: x = in_bit; seed counter counts 8 accepted bits. On the 8th: if the resulting s is 0, restart SEED (counter to 0); otherwise go VERIFY with good counter = 0.
  - VERIFY: x = in_bit. If in_bit == p: good counter +1; reaching SYNC_GOOD -> LOCKED, window counters cleared. If mismatch: -> SEED, seed counter 0 (no err_count update, no err_pulse).
  - LOCKED: x = p (flywheel; received errors never corrupt s). bit_count +1 (saturating). Mismatch: err_pulse=1 next cycle, err_count +1 (saturating at all-ones), window error count +1; if it reaches LOSS_ERRS -> SEED, locked=0. Window bit counter wraps after WINDOW accepted bits; the error on the wrapping bit counts toward the ending window, then window error count is cleared.
- err_clear: clears err_count and bit_count; takes priority over a same-cycle increment (result 0). Does not affect state, locked, or err_pulse.
- reset: state SEED, s=0, all counters 0, locked=0, err_pulse=0, err_count=0, bit_count=0. Valid mid-operation from any state.

## Timing
- All outputs registered; they reflect the bit accepted in the previous cycle.
- From reset with a clean continuous stream, locked rises the cycle after the 24th accepted bit (8 seed + 16 verify).
- err_pulse high exactly one cycle per errored bit; back-to-back errors give back-to-back pulses.
- Loss of lock: locked falls in the cycle after the LOSS_ERRS-th window error; that error still pulses and counts.
- Re-lock after loss takes at least 24 further accepted bits.
- No backpressure; every in_valid bit is consumed.

## Structure
- Package prbs_pkg: PRBS8 tap constant, state enum (SEED, VERIFY, LOCKED), function prbs8_next(s) returning the feedback bit. Shared with the generator side.
- Single module, no sub-modules; the counters and the FSM are small enough to stay flat.

## Test plan
- Clean stream from the LFSR generator (reset value 8'h01), in_valid=1 -> locked=1 after 24th bit, err_count=0, bit_count increments every cycle thereafter.
- Locked, flip one bit -> single err_pulse, err_count=1, locked stays 1, following bits report no error (flywheel).
- Locked, flip 4 bits within 64 -> locked falls after 4th; 3 flips per 64-bit window repeated -> lock held, err_count accumulates.
- Flip one bit during VERIFY -> return to SEED, err_count unchanged, lock after 24 further clean bits.
- All-zero input stream -> never leaves SEED/locked stays 0; in_valid gaps of random length in a clean stream -> same lock point counted in accepted bits.
- err_clear asserted on same cycle as an error bit -> err_count=0, err_pulse still 1; reset asserted while locked -> all outputs 0 next cycle.
